// File: rtl/axi_write_burst_scheduler.sv
// axi_write_burst_scheduler
//   Splits one word-counted write request into AXI4 bursts of at most 2^LEN_W
//   beats that never cross a 4KB page. Each burst issues AW, arms the W-side
//   transfer counter, waits for the last W beat, then consumes B. Only one
//   burst is in flight at any time.
// Ports
//   clk_i, rst_i             clock, synchronous active-high reset
//   start_i/addr_i/length_i  request strobe, start byte address, total words
//   busy_o/done_o/error_o    status: active, completion pulse, sticky bresp error
//   m_aw*                    AW channel (valid/ready/addr/len)
//   transfer_count_o         beats in current burst, for the W counter
//   initiate_transfer_o      pulse arming the W counter (AW handshake cycle)
//   w_done_i                 last W beat accepted
//   m_b*                     B channel (valid/ready/resp)
module axi_write_burst_scheduler #(
  parameter int unsigned AXI_ADDR_W   = 32,
  parameter int unsigned AXI_DATA_W   = 32,
  parameter int unsigned LEN_W        = 8,
  parameter int unsigned MAX_TRANSF_W = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [AXI_ADDR_W-1:0]   addr_i,
  input  logic [MAX_TRANSF_W-1:0] length_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    error_o,
  output logic                    m_awvalid_o,
  input  logic                    m_awready_i,
  output logic [AXI_ADDR_W-1:0]   m_awaddr_o,
  output logic [LEN_W-1:0]        m_awlen_o,
  output logic [MAX_TRANSF_W-1:0] transfer_count_o,
  output logic                    initiate_transfer_o,
  input  logic                    w_done_i,
  input  logic                    m_bvalid_i,
  output logic                    m_bready_o,
  input  logic [1:0]              m_bresp_i
);

  localparam int unsigned BYTES   = AXI_DATA_W / 8;
  localparam int unsigned BYTE_SH = $clog2(BYTES);
  localparam int unsigned MAXB    = 1 << LEN_W;
  localparam int unsigned PAGE_W  = 13;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CALC = 3'd1;
  localparam logic [2:0] S_AW   = 3'd2;
  localparam logic [2:0] S_W    = 3'd3;
  localparam logic [2:0] S_B    = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [2:0]              state_q, state_n;
  logic [AXI_ADDR_W-1:0]   addr_q;
  logic [MAX_TRANSF_W-1:0] remaining_q;
  logic [PAGE_W-1:0]       page_bytes_c;
  logic [MAX_TRANSF_W-1:0] page_beats_c;
  logic [MAX_TRANSF_W-1:0] beats_c;

  // Burst size: min(remaining, MAXB, beats left in the current 4KB page).
  // addr_q is beat-aligned, so the page term is at least one beat.
  always_comb begin
    page_bytes_c = PAGE_W'(4096) - {1'b0, addr_q[11:0]};
    page_beats_c = MAX_TRANSF_W'(page_bytes_c >> BYTE_SH);
    beats_c      = remaining_q;
    if (beats_c > MAX_TRANSF_W'(MAXB)) beats_c = MAX_TRANSF_W'(MAXB);
    if (beats_c > page_beats_c)        beats_c = page_beats_c;
  end

  // Next-state logic.
  always_comb begin
    state_n = state_q;
    case (state_q)
      S_IDLE: if (start_i) state_n = (length_i == '0) ? S_DONE : S_CALC;
      S_CALC: state_n = S_AW;
      S_AW:   if (m_awready_i) state_n = S_W;
      S_W:    if (w_done_i) state_n = S_B;
      S_B:    if (m_bvalid_i) state_n = (remaining_q == transfer_count_o) ? S_DONE : S_CALC;
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_n;
  end

  // The W counter must be armed in the very cycle AW is accepted.
  assign initiate_transfer_o = (state_q == S_AW) && m_awready_i;

  // Registered status/handshake outputs and request datapath.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_o           <= 1'b0;
      done_o           <= 1'b0;
      error_o          <= 1'b0;
      m_awvalid_o      <= 1'b0;
      m_bready_o       <= 1'b0;
      m_awaddr_o       <= '0;
      m_awlen_o        <= '0;
      transfer_count_o <= '0;
      addr_q           <= '0;
      remaining_q      <= '0;
    end else begin
      busy_o      <= (state_n != S_IDLE);
      done_o      <= (state_n == S_DONE);
      m_awvalid_o <= (state_n == S_AW);
      m_bready_o  <= (state_n == S_B);
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            addr_q      <= (addr_i >> BYTE_SH) << BYTE_SH;
            remaining_q <= length_i;
            error_o     <= 1'b0;
          end
        end
        S_CALC: begin
          transfer_count_o <= beats_c;
          m_awaddr_o       <= addr_q;
          m_awlen_o        <= LEN_W'(beats_c - MAX_TRANSF_W'(1));
        end
        S_B: begin
          if (m_bvalid_i) begin
            error_o     <= error_o | (m_bresp_i != 2'b00);
            remaining_q <= remaining_q - transfer_count_o;
            addr_q      <= addr_q + (AXI_ADDR_W'(transfer_count_o) << BYTE_SH);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
